// File: rtl/fsm_pkg.sv
// Shared definitions for the fetch/issue front end and the execute FSM:
// state encoding, RV opcode values and the one-hot opcode class bit positions.
package fsm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        ISSUE  = 3'd3,
        WAIT   = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_LOAD_FP   = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP  = 7'b0100111;
    localparam logic [6:0] OPC_OP_FP     = 7'b1010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;

    localparam int unsigned IDX_LUI       = 0;
    localparam int unsigned IDX_AUIPC     = 1;
    localparam int unsigned IDX_JAL       = 2;
    localparam int unsigned IDX_JALR      = 3;
    localparam int unsigned IDX_BRANCH    = 4;
    localparam int unsigned IDX_LOAD      = 5;
    localparam int unsigned IDX_STORE     = 6;
    localparam int unsigned IDX_LOAD_FP   = 7;
    localparam int unsigned IDX_STORE_FP  = 8;
    localparam int unsigned IDX_OP_FP     = 9;
    localparam int unsigned IDX_OP_IMM_32 = 10;
    localparam int unsigned IDX_OP_IMM    = 11;
    localparam int unsigned IDX_OP        = 12;
    localparam int unsigned IDX_OP_32     = 13;
    localparam int unsigned IDX_SYSTEM    = 14;
    localparam int unsigned IDX_MISC_MEM  = 15;
    localparam int unsigned IDX_ILLEGAL   = 31;

    function automatic logic [31:0] onehotBit(input int unsigned idx);
        return 32'h1 << idx;
    endfunction

endpackage

// File: rtl/opcode_onehot.sv
// Combinational opcode classifier: maps ins[6:0] to a one-hot class word.
// Anything not in the table (including low bits != 2'b11) lands on the ILLEGAL bit.
module opcode_onehot
    import fsm_pkg::*;
(
    input  logic [6:0]  opcode_i,
    output logic [31:0] code_o,
    output logic        illegal_o
);

    always_comb begin
        code_o = onehotBit(IDX_ILLEGAL);
        case (opcode_i)
            OPC_LUI:       code_o = onehotBit(IDX_LUI);
            OPC_AUIPC:     code_o = onehotBit(IDX_AUIPC);
            OPC_JAL:       code_o = onehotBit(IDX_JAL);
            OPC_JALR:      code_o = onehotBit(IDX_JALR);
            OPC_BRANCH:    code_o = onehotBit(IDX_BRANCH);
            OPC_LOAD:      code_o = onehotBit(IDX_LOAD);
            OPC_STORE:     code_o = onehotBit(IDX_STORE);
            OPC_LOAD_FP:   code_o = onehotBit(IDX_LOAD_FP);
            OPC_STORE_FP:  code_o = onehotBit(IDX_STORE_FP);
            OPC_OP_FP:     code_o = onehotBit(IDX_OP_FP);
            OPC_OP_IMM_32: code_o = onehotBit(IDX_OP_IMM_32);
            OPC_OP_IMM:    code_o = onehotBit(IDX_OP_IMM);
            OPC_OP:        code_o = onehotBit(IDX_OP);
            OPC_OP_32:     code_o = onehotBit(IDX_OP_32);
            OPC_SYSTEM:    code_o = onehotBit(IDX_SYSTEM);
            OPC_MISC_MEM:  code_o = onehotBit(IDX_MISC_MEM);
            default:       code_o = onehotBit(IDX_ILLEGAL);
        endcase
        illegal_o = code_o[IDX_ILLEGAL];
    end

endmodule

// File: rtl/fsm_fetch_issue.sv
// Fetch/issue front end for fsm_alu: fetches at the datapath PC, decodes the
// opcode class, pulses start and waits for exec_done before fetching again.
module fsm_fetch_issue
    import fsm_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 16
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [XLEN-1:0] pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ins,
    output logic [31:0]     code,
    output logic            start,
    input  logic            exec_done,
    output logic            illegal,
    output logic            bus_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [31:0]       ins_q, ins_d;
    logic [31:0]       code_q, code_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;

    logic [31:0]       decCode;
    logic              decIllegal;

    opcode_onehot u_decode (
        .opcode_i  (ins_q[6:0]),
        .code_o    (decCode),
        .illegal_o (decIllegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            ins_q     <= '0;
            code_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            ins_q     <= ins_d;
            code_q    <= code_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Every entry into FETCH captures the PC and restarts the ack timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        ins_d     = ins_q;
        code_d    = code_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                    addr_d  = pc;
                    cnt_d   = '0;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    ins_d   = imem_rdata;
                    state_d = DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECODE: begin
                code_d = decCode;
                if (decIllegal) begin
                    illegal_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (exec_done) begin
                    if (run) begin
                        state_d = FETCH;
                        addr_d  = pc;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req  = (state_q == FETCH);
    assign start     = (state_q == ISSUE);
    assign imem_addr = addr_q;
    assign ins       = ins_q;
    assign code      = code_q;
    assign illegal   = illegal_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_fsm_fetch_issue.sv
// Self-checking bench for fsm_fetch_issue: issued instructions are scoreboarded
// when the memory acks and checked when start pulses; control corners checked inline.
module tb_fsm_fetch_issue;

    localparam int XLEN    = 64;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            run;
    logic [XLEN-1:0] pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic [31:0]     ins;
    logic [31:0]     code;
    logic            start;
    logic            exec_done;
    logic            illegal;
    logic            bus_err;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] code;
    } expT;

    expT sbQ[$];
    int  vectorCount = 0;
    int  missCount   = 0;

    always #5 clk = ~clk;

    fsm_fetch_issue #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .pc         (pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ins        (ins),
        .code       (code),
        .start      (start),
        .exec_done  (exec_done),
        .illegal    (illegal),
        .bus_err    (bus_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".req"},     imem_req,  0);
        checkOutput({tag, ".addr"},    imem_addr, 0);
        checkOutput({tag, ".ins"},     ins,       0);
        checkOutput({tag, ".code"},    code,      0);
        checkOutput({tag, ".start"},   start,     0);
        checkOutput({tag, ".illegal"}, illegal,   0);
        checkOutput({tag, ".busErr"},  bus_err,   0);
    endtask

    task automatic applyReset(input string tag);
        reset = 1'b1;
        tick();
        checkAllZero(tag);
        reset = 1'b0;
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at the first WAIT negedge.
    task automatic applyStimulus(input logic [31:0] rdata, input logic [31:0] expCode,
                                 input int ackDelay, input logic [XLEN-1:0] expAddr);
        checkOutput("fetchReq",  imem_req,  1);
        checkOutput("fetchAddr", imem_addr, expAddr);
        for (int d = 0; d < ackDelay; d++) begin
            pc = pc + 64'h100;
            tick();
            checkOutput("reqHeld",    imem_req,  1);
            checkOutput("addrFrozen", imem_addr, expAddr);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        sbQ.push_back('{ins: rdata, code: expCode});
        tick();
        imem_ack = 1'b0;
        checkOutput("decodeNoStart", start, 0);
        checkOutput("decodeIns",     ins,   rdata);
        tick();
        checkOutput("startAfterAck", start, 1);
        tick();
        checkOutput("startOnePulse", start,    0);
        checkOutput("waitNoReq",     imem_req, 0);
    endtask

    // Entered at the first WAIT negedge; raises exec_done after extraWait cycles.
    task automatic finishAndRefetch(input logic [XLEN-1:0] newPc, input int extraWait);
        for (int w = 0; w < extraWait; w++) begin
            tick();
            checkOutput("waitIdleReq", imem_req, 0);
        end
        exec_done = 1'b1;
        pc        = newPc;
        tick();
        exec_done = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        expT e;
        if (reset === 1'b0 && start === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedStart", 1, 0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("issueIns",  ins,  e.ins);
                checkOutput("issueCode", code, e.code);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] tblIns  [6];
    logic [31:0] tblCode [6];

    initial begin : main
        int count;
        tblIns[0] = 32'h000002B7; tblCode[0] = 32'h00000001;
        tblIns[1] = 32'h0000006F; tblCode[1] = 32'h00000004;
        tblIns[2] = 32'h00003003; tblCode[2] = 32'h00000020;
        tblIns[3] = 32'h00000073; tblCode[3] = 32'h00004000;
        tblIns[4] = 32'h0000000F; tblCode[4] = 32'h00008000;
        tblIns[5] = 32'h0000003B; tblCode[5] = 32'h00002000;

        reset      = 1'b1;
        run        = 1'b0;
        pc         = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        exec_done  = 1'b0;
        tick();
        applyReset("reset");

        exec_done = 1'b1;
        tick();
        checkOutput("idleDoneReq",   imem_req, 0);
        checkOutput("idleDoneStart", start,    0);
        exec_done = 1'b0;

        run        = 1'b1;
        pc         = 64'h0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h001102B3;
        sbQ.push_back('{ins: 32'h001102B3, code: 32'h00001000});
        count = 0;
        while (count < 10) begin
            tick();
            count++;
            if (count == 1) begin
                checkOutput("firstReq",  imem_req,  1);
                checkOutput("firstAddr", imem_addr, 64'h0);
            end
            if (start === 1'b1) break;
        end
        imem_ack = 1'b0;
        checkOutput("startLatency", count, 3);
        tick();
        checkOutput("firstOnePulse", start, 0);

        finishAndRefetch(64'h4, 3);
        applyStimulus(32'h00A08313, 32'h00000800, 0, 64'h4);

        finishAndRefetch(64'h8, 0);
        applyStimulus(32'h000002B7, 32'h00000001, 5, 64'h8);

        for (int i = 0; i < 6; i++) begin
            finishAndRefetch(64'h1000 + 64'(i * 4), i % 2);
            applyStimulus(tblIns[i], tblCode[i], $urandom_range(0, 3), 64'h1000 + 64'(i * 4));
        end

        run       = 1'b0;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        checkOutput("runLowIdle0", imem_req, 0);
        tick();
        checkOutput("runLowIdle1", imem_req, 0);

        run = 1'b1;
        pc  = 64'h200;
        tick();
        run = 1'b0;
        applyStimulus(32'h40B50533, 32'h00001000, 2, 64'h200);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        checkOutput("dropIdle0", imem_req, 0);
        tick();
        checkOutput("dropIdle1", imem_req, 0);

        run = 1'b1;
        pc  = 64'h300;
        tick();
        applyStimulus(32'h001102B3, 32'h00001000, 0, 64'h300);
        run = 1'b0;
        applyReset("resetInWait");

        run = 1'b1;
        pc  = 64'h400;
        tick();
        checkOutput("preResetReq", imem_req, 1);
        run        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h00A08313;
        applyReset("resetInFetch");
        imem_ack = 1'b0;
        tick();
        checkOutput("postResetIdle", imem_req, 0);

        run = 1'b1;
        pc  = 64'h500;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFFFFFF;
        tick();
        imem_ack = 1'b0;
        tick();
        checkOutput("illegalFlag", illegal,  1);
        checkOutput("illegalCode", code,     32'h80000000);
        checkOutput("illegalIns",  ins,      32'hFFFFFFFF);
        checkOutput("illegalReq",  imem_req, 0);
        repeat (5) tick();
        checkOutput("illegalHold",    illegal,  1);
        checkOutput("illegalHoldReq", imem_req, 0);
        run = 1'b0;
        applyReset("resetAfterIllegal");

        run = 1'b1;
        pc  = 64'h600;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h001102B2;
        tick();
        imem_ack = 1'b0;
        tick();
        checkOutput("lowBitsIllegal", illegal, 1);
        checkOutput("lowBitsCode",    code,    32'h80000000);
        run = 1'b0;
        applyReset("resetAfterLowBits");

        run = 1'b1;
        pc  = 64'h700;
        tick();
        count = 0;
        while (imem_req === 1'b1 && count < 40) begin
            count++;
            tick();
        end
        checkOutput("timeoutCycles", count,    TIMEOUT);
        checkOutput("timeoutBusErr", bus_err,  1);
        checkOutput("timeoutReq",    imem_req, 0);
        repeat (4) tick();
        checkOutput("busErrHold",    bus_err,  1);
        checkOutput("busErrHoldReq", imem_req, 0);
        run = 1'b0;
        applyReset("resetAfterTimeout");

        checkOutput("scoreboardEmpty", sbQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
